sysop_issue_unit: RTL and testbench
===================================

Name: sysop_issue_unit

Overview:
- Processor-side counterpart of the BIOS supervisor. It turns decoded system instructions into one-cycle opcode/info transactions toward the BIOS, returns BIOS data to the register file, and drives the instruction-boundary flag `done_inst`.
- It tracks the BIOS `controll` level to switch the fetch PC between BIOS code and the user process. On preemption it saves the process PC; on release it restores it.
- It sits between decode/execute and the BIOS, beside the PC register.

Parameters:
- BIOS_ENTRY, 32'd0, fetch address loaded when control returns to the BIOS.
- DATA_W, 32, width of operand, info and PC paths.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- inst_valid  in  1  decode presents a system instruction.
- inst_opcode  in  8  system opcode (values in the package).
- inst_operand  in  32  register operand (quantum value, new PC).
- inst_ready  out  1  instruction retired this cycle.
- processor_opcode_operation  out  8  opcode to the BIOS; NOP 8'h00 when idle.
- processor_info  out  32  operand to the BIOS.
- done_inst  out  1  processor is at an instruction boundary.
- controll  in  1  BIOS control level: 1 = BIOS executing, 0 = process executing.
- write_process_pc  in  1  BIOS strobe confirming SETPC.
- bios_info  in  32  BIOS return data (GETTIME/GETQUANTUM).
- pc_cur  in  32  current fetch PC.
- pc_load  out  1  one-cycle strobe to load pc_next.
- pc_next  out  32  PC to load.
- result_we  out  1  register-file write strobe.
- result_data  out  32  register-file write data.
- bios_mode  out  1  registered copy of the current mode.

Behaviour:
- Reset values:
  - state=IDLE; processor_opcode_operation=8'h00; processor_info=0.
  - inst_ready=0; done_inst=1; pc_load=0; pc_next=0; result_we=0; result_data=0.
  - saved_pc=0; ctl_q=1; bios_mode=1. ctl_q=1 at reset so that no spurious edge is seen while the BIOS starts in BIOS mode.
- States: IDLE, ISSUE, WAIT_INFO, SWITCH.
- IDLE:
  - done_inst=1.
  - If inst_valid and no controll edge this cycle → ISSUE.
  - Latch the opcode into processor_opcode_operation and the operand into processor_info.
- ISSUE (exactly 1 cycle):
  - The opcode/info pair is held for this single cycle; the BIOS samples it on the posedge.
  - done_inst=1, so BIOSINT and done_inst coincide.
  - GETTIME (0xB0) and GETQUANTUM (0xB3) → WAIT_INFO.
  - All other opcodes: inst_ready=1 → IDLE, and the opcode returns to 8'h00.
- WAIT_INFO (1 cycle):
  - done_inst=0.
  - Capture bios_info into result_data; result_we=1; inst_ready=1 → IDLE.
- Controll edge detection uses ctl_q, sampled every cycle.
  - Rising edge 0→1 (preemption or HALT):
    - saved_pc ← pc_cur.
    - pc_next=BIOS_ENTRY, pc_load=1, bios_mode ← 1 → SWITCH.
  - Falling edge 1→0 (BIOSINT release):
    - pc_next=saved_pc, pc_load=1, bios_mode ← 0 → SWITCH.
- SWITCH (1 cycle): done_inst=0, opcode NOP → IDLE.
- SETPC (0x03):
  - The ISSUE cycle sends the operand on processor_info.
  - When write_process_pc=1 (next cycle), saved_pc ← latched processor_info.
  - If write_process_pc rises with no SETPC outstanding, it is ignored.
- Priority when events coincide:
  - A controll edge beats inst_valid in IDLE: the instruction is not accepted (inst_ready=0) and decode retries.
  - An edge seen during ISSUE/WAIT_INFO is deferred one cycle. The ctl_q compare is held until IDLE, and no edge is lost.
  - write_process_pc in the same cycle as a falling edge: the new PC wins. pc_next uses the just-written value (bypass).
- HALT (0x01), LOCK (0xB1), RELEASE (0xB2), SETQUANTUM (0xB4) and BIOSINT (0xB5) are single-cycle: only the ISSUE transaction.
- Unknown opcode: not issued; inst_ready=1 in 1 cycle, opcode stays NOP.
- Reset mid-operation (any state) returns to reset values next cycle. No result_we or pc_load is generated from a pending op.
- Widths: all PC/info paths are DATA_W, no arithmetic, no wrap concerns.

Decomposition:
- Package sysop_pkg: 8-bit opcode constants (NOP 00, HALT 01, SETPC 03, GETTIME B0, LOCK B1, RELEASE B2, GETQUANTUM B3, SETQUANTUM B4, BIOSINT B5), the state encoding, and a "returns data" classifier.
- Sub-module: ctl_edge_detect (registered controll, rise/fall pulses, hold input for deferral).

Test Plan:
- Reset: after reset, done_inst=1, bios_mode=1, opcode=8'h00, pc_load=0 with controll=1 held → no pc_load for 10 cycles.
- SETQUANTUM, operand 100: opcode=8'hB4, info=100 for exactly one cycle with done_inst=1; inst_ready next edge; opcode back to 8'h00.
- GETTIME with bios_info=32'h2A one cycle after ISSUE: result_we=1, result_data=32'h2A, inst_ready asserted in WAIT_INFO, done_inst=0 that cycle.
- SETPC 32'h40, then write_process_pc pulse, then BIOSINT with controll falling: pc_load=1, pc_next=32'h40, bios_mode=0.
- Process at pc_cur=32'h57, controll rises: pc_next=BIOS_ENTRY (0), saved_pc=32'h57. A later controll fall restores pc_next=32'h57.
- inst_valid GETQUANTUM coincident with a controll rising edge: switch first, inst_ready=0. The instruction is accepted after SWITCH. Reset asserted in WAIT_INFO → no result_we.

Source files
------------

// File: rtl/sysop_pkg.sv
// sysop_pkg: shared definitions for the system-instruction issue unit.
//   - 8-bit system opcodes exchanged with the BIOS
//   - issue FSM state encoding
//   - opcode classifiers (known opcode, opcode that returns BIOS data)
package sysop_pkg;

    localparam logic [7:0] OP_NOP        = 8'h00;
    localparam logic [7:0] OP_HALT       = 8'h01;
    localparam logic [7:0] OP_SETPC      = 8'h03;
    localparam logic [7:0] OP_GETTIME    = 8'hB0;
    localparam logic [7:0] OP_LOCK       = 8'hB1;
    localparam logic [7:0] OP_RELEASE    = 8'hB2;
    localparam logic [7:0] OP_GETQUANTUM = 8'hB3;
    localparam logic [7:0] OP_SETQUANTUM = 8'hB4;
    localparam logic [7:0] OP_BIOSINT    = 8'hB5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_INFO = 2'd2,
        ST_SWITCH    = 2'd3
    } state_e;

    // Opcodes that wait one extra cycle for bios_info.
    function automatic logic returns_data(input logic [7:0] op);
        return (op == OP_GETTIME) || (op == OP_GETQUANTUM);
    endfunction

    // Opcodes that are forwarded to the BIOS. NOP is not a system instruction.
    function automatic logic is_known(input logic [7:0] op);
        logic known;
        case (op)
            OP_HALT, OP_SETPC, OP_GETTIME, OP_LOCK, OP_RELEASE,
            OP_GETQUANTUM, OP_SETQUANTUM, OP_BIOSINT: known = 1'b1;
            default:                                  known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/sysop_issue_unit_ctl_edge_detect.sv
// ctl_edge_detect: registered copy of the BIOS control level with rise/fall
// detection. While hold_i is high the registered copy is frozen, so an edge
// that arrives while the issue FSM is busy stays visible until it is idle.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (copy resets to 1)
//   ctl_i       - live control level
//   hold_i      - freeze the registered copy (defer edge)
//   rise_o      - ctl_i=1 while copy=0
//   fall_o      - ctl_i=0 while copy=1
module ctl_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic ctl_i,
    input  logic hold_i,
    output logic rise_o,
    output logic fall_o
);

    logic ctl_q;
    logic ctl_d;

    // Next value of the registered control level.
    always_comb begin
        ctl_d = ctl_q;
        if (hold_i) begin
            ctl_d = ctl_q;
        end else begin
            ctl_d = ctl_i;
        end
    end

    // Control level register; resets to BIOS mode so no edge is seen at start.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_q <= 1'b1;
        end else begin
            ctl_q <= ctl_d;
        end
    end

    assign rise_o = ctl_i & ~ctl_q;
    assign fall_o = ~ctl_i & ctl_q;

endmodule

// File: rtl/sysop_issue_unit.sv
// sysop_issue_unit: turns decoded system instructions into one-cycle
// opcode/info transactions toward the BIOS, returns BIOS data to the register
// file and switches the fetch PC between BIOS code and the user process on
// edges of the BIOS control level.
// All outputs are registered: a strobe decided in cycle N is visible in N+1.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   inst_valid/opcode/operand        - system instruction from decode
//   inst_ready                       - instruction retired
//   processor_opcode_operation/info  - transaction to the BIOS (NOP when idle)
//   done_inst                        - instruction boundary flag
//   controll, write_process_pc       - BIOS control level, SETPC confirm
//   bios_info                        - BIOS return data
//   pc_cur / pc_load / pc_next       - fetch PC interface
//   result_we / result_data          - register-file write
//   bios_mode                        - current mode (1 = BIOS)
module sysop_issue_unit
    import sysop_pkg::*;
#(
    parameter int unsigned        DATA_W     = 32,
    parameter logic [DATA_W-1:0]  BIOS_ENTRY = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_valid,
    input  logic [7:0]        inst_opcode,
    input  logic [DATA_W-1:0] inst_operand,
    output logic              inst_ready,
    output logic [7:0]        processor_opcode_operation,
    output logic [DATA_W-1:0] processor_info,
    output logic              done_inst,
    input  logic              controll,
    input  logic              write_process_pc,
    input  logic [DATA_W-1:0] bios_info,
    input  logic [DATA_W-1:0] pc_cur,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_next,
    output logic              result_we,
    output logic [DATA_W-1:0] result_data,
    output logic              bios_mode
);

    state_e              state_q, state_d;
    logic [7:0]          opcode_q, opcode_d;
    logic [DATA_W-1:0]   info_q, info_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                pc_load_q, pc_load_d;
    logic [DATA_W-1:0]   pc_next_q, pc_next_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   saved_pc_q, saved_pc_d;
    logic                mode_q, mode_d;
    logic                setpc_pend_q, setpc_pend_d;
    logic                ctl_rise_s, ctl_fall_s;
    logic                setpc_wr_s;

    ctl_edge_detect u_edge (
        .clk    (clk),
        .reset  (reset),
        .ctl_i  (controll),
        .hold_i (state_q != ST_IDLE),
        .rise_o (ctl_rise_s),
        .fall_o (ctl_fall_s)
    );

    // SETPC confirmation only counts in the single cycle after a SETPC issue.
    assign setpc_wr_s = write_process_pc & setpc_pend_q;

    // Next-state and next-output logic of the issue FSM.
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        info_d       = info_q;
        ready_d      = 1'b0;
        done_d       = 1'b1;
        pc_load_d    = 1'b0;
        pc_next_d    = pc_next_q;
        we_d         = 1'b0;
        rdata_d      = rdata_q;
        saved_pc_d   = saved_pc_q;
        mode_d       = mode_q;
        setpc_pend_d = 1'b0;

        if (setpc_wr_s) begin
            saved_pc_d = info_q;
        end else begin
            saved_pc_d = saved_pc_q;
        end

        case (state_q)
            ST_IDLE: begin
                // Control edges win over a new instruction; decode retries.
                if (ctl_rise_s) begin
                    if (!setpc_wr_s) begin
                        saved_pc_d = pc_cur;
                    end else begin
                        saved_pc_d = info_q;
                    end
                    pc_next_d = BIOS_ENTRY;
                    pc_load_d = 1'b1;
                    mode_d    = 1'b1;
                    done_d    = 1'b0;
                    state_d   = ST_SWITCH;
                end else if (ctl_fall_s) begin
                    // A PC written this very cycle is restored (bypass).
                    pc_next_d = setpc_wr_s ? info_q : saved_pc_q;
                    pc_load_d = 1'b1;
                    mode_d    = 1'b0;
                    done_d    = 1'b0;
                    state_d   = ST_SWITCH;
                end else if (inst_valid) begin
                    if (is_known(inst_opcode)) begin
                        opcode_d = inst_opcode;
                        info_d   = inst_operand;
                        state_d  = ST_ISSUE;
                    end else begin
                        ready_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                opcode_d = OP_NOP;
                if (returns_data(opcode_q)) begin
                    done_d  = 1'b0;
                    state_d = ST_WAIT_INFO;
                end else begin
                    ready_d      = 1'b1;
                    setpc_pend_d = (opcode_q == OP_SETPC);
                    state_d      = ST_IDLE;
                end
            end
            ST_WAIT_INFO: begin
                rdata_d = bios_info;
                we_d    = 1'b1;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            ST_SWITCH: begin
                opcode_d = OP_NOP;
                state_d  = ST_IDLE;
            end
            default: begin
                opcode_d = OP_NOP;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            opcode_q     <= OP_NOP;
            info_q       <= {DATA_W{1'b0}};
            ready_q      <= 1'b0;
            done_q       <= 1'b1;
            pc_load_q    <= 1'b0;
            pc_next_q    <= {DATA_W{1'b0}};
            we_q         <= 1'b0;
            rdata_q      <= {DATA_W{1'b0}};
            saved_pc_q   <= {DATA_W{1'b0}};
            mode_q       <= 1'b1;
            setpc_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            info_q       <= info_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            pc_load_q    <= pc_load_d;
            pc_next_q    <= pc_next_d;
            we_q         <= we_d;
            rdata_q      <= rdata_d;
            saved_pc_q   <= saved_pc_d;
            mode_q       <= mode_d;
            setpc_pend_q <= setpc_pend_d;
        end
    end

    assign processor_opcode_operation = opcode_q;
    assign processor_info             = info_q;
    assign inst_ready                 = ready_q;
    assign done_inst                  = done_q;
    assign pc_load                    = pc_load_q;
    assign pc_next                    = pc_next_q;
    assign result_we                  = we_q;
    assign result_data                = rdata_q;
    assign bios_mode                  = mode_q;

endmodule

// File: tb/tb_sysop_issue_unit.sv
module tb_sysop_issue_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic [7:0]  inst_opcode;
    logic [31:0] inst_operand;
    logic        inst_ready;
    logic [7:0]  processor_opcode_operation;
    logic [31:0] processor_info;
    logic        done_inst;
    logic        controll;
    logic        write_process_pc;
    logic [31:0] bios_info;
    logic [31:0] pc_cur;
    logic        pc_load;
    logic [31:0] pc_next;
    logic        result_we;
    logic [31:0] result_data;
    logic        bios_mode;

    sysop_issue_unit #(.DATA_W(32), .BIOS_ENTRY(32'd0)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .inst_valid                 (inst_valid),
        .inst_opcode                (inst_opcode),
        .inst_operand               (inst_operand),
        .inst_ready                 (inst_ready),
        .processor_opcode_operation (processor_opcode_operation),
        .processor_info             (processor_info),
        .done_inst                  (done_inst),
        .controll                   (controll),
        .write_process_pc           (write_process_pc),
        .bios_info                  (bios_info),
        .pc_cur                     (pc_cur),
        .pc_load                    (pc_load),
        .pc_next                    (pc_next),
        .result_we                  (result_we),
        .result_data                (result_data),
        .bios_mode                  (bios_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] info;
        logic        done;
        logic        ready;
        logic        we;
        logic [31:0] rdata;
        logic        pcl;
        logic [31:0] pcn;
        logic        mode;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [7:0] op, input logic [31:0] info, input logic done,
                        input logic ready, input logic we, input logic [31:0] rdata,
                        input logic pcl, input logic [31:0] pcn, input logic mode);
        exp_t e;
        e.op = op; e.info = info; e.done = done; e.ready = ready; e.we = we;
        e.rdata = rdata; e.pcl = pcl; e.pcn = pcn; e.mode = mode;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle that shows activity is matched against the next expectation.
    always @(negedge clk) begin
        if (mon_en && ((processor_opcode_operation !== 8'h00) || (inst_ready !== 1'b0) ||
                       (result_we !== 1'b0) || (pc_load !== 1'b0) || (done_inst !== 1'b1))) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got op=%0h rdy=%0b we=%0b pcl=%0b done=%0b expected no activity at %0t",
                         processor_opcode_operation, inst_ready, result_we, pc_load, done_inst, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("opcode", {24'd0, processor_opcode_operation}, {24'd0, e.op});
                chk("info", processor_info, e.info);
                chk("done_inst", {31'd0, done_inst}, {31'd0, e.done});
                chk("inst_ready", {31'd0, inst_ready}, {31'd0, e.ready});
                chk("result_we", {31'd0, result_we}, {31'd0, e.we});
                chk("pc_load", {31'd0, pc_load}, {31'd0, e.pcl});
                chk("bios_mode", {31'd0, bios_mode}, {31'd0, e.mode});
                if (e.we) chk("result_data", result_data, e.rdata);
                if (e.pcl) chk("pc_next", pc_next, e.pcn);
            end
        end
    end

    initial begin
        reset = 1'b1; inst_valid = 1'b0; inst_opcode = 8'h00; inst_operand = 32'd0;
        controll = 1'b1; write_process_pc = 1'b0; bios_info = 32'd0; pc_cur = 32'd0;
        repeat (3) tick();
        reset = 1'b0;
        mon_en = 1'b1;
        // Reset state, then ten quiet cycles with controll held high.
        chk("rst_done", {31'd0, done_inst}, 32'd1);
        chk("rst_mode", {31'd0, bios_mode}, 32'd1);
        chk("rst_opcode", {24'd0, processor_opcode_operation}, 32'd0);
        chk("rst_pc_load", {31'd0, pc_load}, 32'd0);
        chk("rst_ready", {31'd0, inst_ready}, 32'd0);
        chk("rst_info", processor_info, 32'd0);
        repeat (10) tick();

        // SETQUANTUM 100: one ISSUE cycle, then inst_ready with NOP.
        push(8'hB4, 32'd100, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        push(8'h00, 32'd100, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        inst_valid = 1'b1; inst_opcode = 8'hB4; inst_operand = 32'd100;
        tick(); inst_valid = 1'b0;
        repeat (3) tick();

        // GETTIME: ISSUE, WAIT_INFO (done=0), then write-back of 0x2A.
        push(8'hB0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        push(8'h00, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        push(8'h00, 32'd0, 1'b1, 1'b1, 1'b1, 32'h2A, 1'b0, 32'd0, 1'b1);
        inst_valid = 1'b1; inst_opcode = 8'hB0; inst_operand = 32'd0;
        tick(); inst_valid = 1'b0;
        tick(); bios_info = 32'h2A;
        tick(); bios_info = 32'd0;
        repeat (2) tick();

        // SETPC 0x40 + confirm, then BIOSINT with controll falling during ISSUE.
        push(8'h03, 32'h40, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        push(8'h00, 32'h40, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        inst_valid = 1'b1; inst_opcode = 8'h03; inst_operand = 32'h40;
        tick(); inst_valid = 1'b0;
        tick(); write_process_pc = 1'b1;
        tick(); write_process_pc = 1'b0;
        tick();
        push(8'hB5, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        push(8'h00, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        push(8'h00, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h40, 1'b0);
        inst_valid = 1'b1; inst_opcode = 8'hB5; inst_operand = 32'd0;
        tick(); inst_valid = 1'b0; controll = 1'b0;
        repeat (4) tick();

        // Preemption at pc_cur=0x57, later release restores it.
        push(8'h00, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b1);
        pc_cur = 32'h57; controll = 1'b1;
        repeat (3) tick();
        pc_cur = 32'h1000;
        push(8'h00, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h57, 1'b0);
        controll = 1'b0;
        repeat (3) tick();

        // GETQUANTUM coincident with rising edge: switch first, then accept; reset in WAIT_INFO.
        push(8'h00, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b1);
        push(8'hB3, 32'd7, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        push(8'h00, 32'd7, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        controll = 1'b1; pc_cur = 32'h99;
        inst_valid = 1'b1; inst_opcode = 8'hB3; inst_operand = 32'd7;
        tick();                         // SWITCH
        tick();                         // IDLE, accepted
        tick(); inst_valid = 1'b0;      // ISSUE
        tick(); reset = 1'b1; bios_info = 32'h55;   // WAIT_INFO
        tick(); reset = 1'b0; bios_info = 32'd0;
        chk("midrst_we", {31'd0, result_we}, 32'd0);
        chk("midrst_ready", {31'd0, inst_ready}, 32'd0);
        chk("midrst_mode", {31'd0, bios_mode}, 32'd1);
        chk("midrst_done", {31'd0, done_inst}, 32'd1);
        chk("midrst_info", processor_info, 32'd0);
        repeat (3) tick();

        // LOCK, then a stray write_process_pc must not change saved_pc (still 0).
        push(8'hB1, 32'h123, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        push(8'h00, 32'h123, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        inst_valid = 1'b1; inst_opcode = 8'hB1; inst_operand = 32'h123;
        tick(); inst_valid = 1'b0;
        repeat (3) tick();
        write_process_pc = 1'b1;
        tick(); write_process_pc = 1'b0;
        tick();
        push(8'h00, 32'h123, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0);
        controll = 1'b0;
        repeat (3) tick();

        // Unknown opcode: ready one cycle later, opcode stays NOP.
        push(8'h00, 32'h123, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        inst_valid = 1'b1; inst_opcode = 8'h77; inst_operand = 32'd5;
        tick(); inst_valid = 1'b0;
        repeat (2) tick();

        // Preempt at 0x80, then SETPC 0x200 whose confirm coincides with the release edge.
        push(8'h00, 32'h123, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b1);
        pc_cur = 32'h80; controll = 1'b1;
        repeat (3) tick();
        push(8'h03, 32'h200, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        push(8'h00, 32'h200, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        push(8'h00, 32'h200, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h200, 1'b0);
        inst_valid = 1'b1; inst_opcode = 8'h03; inst_operand = 32'h200;
        tick(); inst_valid = 1'b0; controll = 1'b0;   // ISSUE, edge deferred
        tick(); write_process_pc = 1'b1;              // IDLE: fall + confirm
        tick(); write_process_pc = 1'b0;              // SWITCH
        repeat (3) tick();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
